// File: rtl/shot_clock_pkg.sv
// Shared types and constants for the shot clock: state encoding, count width
// and the default timing parameters.
package shot_clock_pkg;

  localparam int CNT_W          = 4;
  localparam int DEF_TICK_DIV   = 4;
  localparam int DEF_START_VAL  = 14;
  localparam int DEF_BUZZ_TICKS = 3;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    COUNT = 2'd1,
    BUZZ  = 2'd2
  } state_t;

endpackage

// File: rtl/shot_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and flags the last cycle of each window as
// a tick. clr restarts the window so every state begins on a fresh boundary.
module shot_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;

  assign tick = (pre_q == LAST);

  always_comb begin
    pre_d = pre_q + PW'(1);
    if (clr || tick) pre_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) pre_q <= '0;
    else       pre_q <= pre_d;
  end

endmodule

// File: rtl/shot_clock.sv
// Self-running shot clock: reload, count down once per prescaled tick while
// shoot is high, sound buzz for BUZZ_TICKS ticks at zero, then repeat.
module shot_clock
  import shot_clock_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int START_VAL  = DEF_START_VAL,
  parameter int BUZZ_TICKS = DEF_BUZZ_TICKS
) (
  input  logic             clk,
  input  logic             nrst,
  output logic [CNT_W-1:0] count,
  output logic             shoot,
  output logic             buzz
);

  localparam int BW = $clog2(BUZZ_TICKS + 1);
  localparam logic [BW-1:0]    BLAST = BW'(BUZZ_TICKS - 1);
  localparam logic [CNT_W-1:0] START = CNT_W'(START_VAL);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             shoot_q, shoot_d;
  logic             buzz_q, buzz_d;
  logic [BW-1:0]    btick_q, btick_d;
  logic             tick;
  logic             clr;

  // LOAD holds the prescaler at zero; any state change restarts it
  assign clr = (state_q == LOAD) || (state_d != state_q);

  shot_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .nrst (nrst),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= LOAD;
      count_q <= START;
      shoot_q <= 1'b0;
      buzz_q  <= 1'b0;
      btick_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shoot_q <= shoot_d;
      buzz_q  <= buzz_d;
      btick_q <= btick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    state_d = COUNT;
      COUNT:   if (tick && count_q == CNT_W'(1)) state_d = BUZZ;
      BUZZ:    if (tick && btick_q == BLAST) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    count_d = count_q;
    shoot_d = shoot_q;
    buzz_d  = buzz_q;
    btick_d = btick_q;
    case (state_q)
      LOAD: begin
        count_d = START;
        shoot_d = 1'b1;
        buzz_d  = 1'b0;
        btick_d = '0;
      end
      COUNT: begin
        // count_q is at least 1 here, so the decrement cannot wrap
        if (tick) begin
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            shoot_d = 1'b0;
            buzz_d  = 1'b1;
            btick_d = '0;
          end
        end
      end
      BUZZ: begin
        if (tick) begin
          if (btick_q == BLAST) begin
            count_d = START;
            shoot_d = 1'b0;
            buzz_d  = 1'b0;
            btick_d = '0;
          end else begin
            btick_d = btick_q + BW'(1);
          end
        end
      end
      default: begin
        count_d = START;
        shoot_d = 1'b0;
        buzz_d  = 1'b0;
        btick_d = '0;
      end
    endcase
  end

  assign count = count_q;
  assign shoot = shoot_q;
  assign buzz  = buzz_q;

endmodule

// File: tb/tb_shot_clock.sv
// Bench for shot_clock: a default instance and a minimal (1,1,1) instance are
// checked every cycle against a phase-within-period model of the waveform.
module tb_shot_clock;

  logic       clk;
  logic       nrst;
  logic [3:0] count_a, count_b;
  logic       shoot_a, shoot_b, buzz_a, buzz_b;

  int checks = 0;
  int errors = 0;
  int k      = -1;   // edges since reset release; -1 while in reset

  shot_clock dut_a (
    .clk   (clk),
    .nrst  (nrst),
    .count (count_a),
    .shoot (shoot_a),
    .buzz  (buzz_a)
  );

  shot_clock #(.TICK_DIV(1), .START_VAL(1), .BUZZ_TICKS(1)) dut_b (
    .clk   (clk),
    .nrst  (nrst),
    .count (count_b),
    .shoot (shoot_b),
    .buzz  (buzz_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs after the k-th active edge, from the phase within one period
  function automatic void model(input int kk, input int td, input int s, input int b,
                                output logic [3:0] c, output logic sh, output logic bz);
    int p, per;
    per = 1 + td * (s + b);
    c = 4'(s); sh = 1'b0; bz = 1'b0;
    if (kk >= 0) begin
      p = kk % per;
      if (p < td * s) begin
        c = 4'(s - p / td); sh = 1'b1;
      end else if (p < td * (s + b)) begin
        c = 4'd0; bz = 1'b1;
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s k=%0d actual=%0d expected=%0d", name, k, act, exp_v);
    end
  endtask

  always @(posedge clk) begin
    if (!nrst) k = -1;
    else       k = k + 1;
  end

  always @(negedge clk) begin
    logic [3:0] ec;
    logic       es, eb;
    model(k, 4, 14, 3, ec, es, eb);
    chk("a_count", int'(count_a), int'(ec));
    chk("a_shoot", int'(shoot_a), int'(es));
    chk("a_buzz",  int'(buzz_a),  int'(eb));
    chk("a_excl",  int'(shoot_a & buzz_a), 0);
    model(k, 1, 1, 1, ec, es, eb);
    chk("b_count", int'(count_b), int'(ec));
    chk("b_shoot", int'(shoot_b), int'(es));
    chk("b_buzz",  int'(buzz_b),  int'(eb));
    chk("b_excl",  int'(shoot_b & buzz_b), 0);
    // literal anchors for the model
    case (k)
      0:  begin chk("lit_e0_count", int'(count_a), 14); chk("lit_e0_shoot", int'(shoot_a), 1);
                chk("lit_b0_count", int'(count_b), 1);  chk("lit_b0_shoot", int'(shoot_b), 1); end
      1:  begin chk("lit_b1_count", int'(count_b), 0);  chk("lit_b1_buzz", int'(buzz_b), 1); end
      2:  begin chk("lit_b2_count", int'(count_b), 1);  chk("lit_b2_shoot", int'(shoot_b), 0); end
      3:  begin chk("lit_e3_count", int'(count_a), 14); chk("lit_b3_shoot", int'(shoot_b), 1); end
      4:  chk("lit_e4_count", int'(count_a), 13);
      55: chk("lit_e55_count", int'(count_a), 1);
      56: begin chk("lit_e56_buzz", int'(buzz_a), 1);   chk("lit_e56_shoot", int'(shoot_a), 0); end
      67: chk("lit_e67_buzz", int'(buzz_a), 1);
      68: begin chk("lit_e68_count", int'(count_a), 14); chk("lit_e68_buzz", int'(buzz_a), 0);
                chk("lit_e68_shoot", int'(shoot_a), 0); end
      69: chk("lit_e69_shoot", int'(shoot_a), 1);
      125: chk("lit_e125_buzz", int'(buzz_a), 1);
      138: chk("lit_e138_shoot", int'(shoot_a), 1);
      default: ;
    endcase
  end

  initial begin
    nrst = 1'b0;
    repeat (10) @(negedge clk);
    nrst = 1'b1;
    // three full periods plus margin
    repeat (3 * 69 + 10) @(negedge clk);
    // advance into BUZZ (phase 60) and pulse reset for one edge
    begin
      int guard = 0;
      while ((k % 69) != 60 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        errors++;
        $display("FAIL buzz_wait k=%0d actual=timeout expected=phase60", k);
      end
    end
    chk("pre_reset_buzz", int'(buzz_a), 1);
    nrst = 1'b0;
    @(negedge clk);
    chk("mid_reset_count", int'(count_a), 14);
    chk("mid_reset_buzz",  int'(buzz_a), 0);
    chk("mid_reset_shoot", int'(shoot_a), 0);
    nrst = 1'b1;
    @(negedge clk);
    chk("restart_shoot", int'(shoot_a), 1);
    chk("restart_count", int'(count_a), 14);
    repeat (80) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
